// File: rtl/cdb_arbiter_if.sv
// Global clock/reset/flush bundle shared by the scheduler blocks.
// The rest modport is the read-only view used by consumers of these signals.
interface global_signals_if;
  logic clk;
  logic reset;
  logic delete;

  modport rest (
    input clk,
    input reset,
    input delete
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: grants up to two distinct requesters per cycle onto cdb[0]/cdb[1]
// with round-robin fairness and an optional bounded lock that lets an owner keep its bus.
module cdb_arbiter #(
  parameter int          NUM_REQ   = 8,
  parameter int          MAX_HOLD  = 4,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
  global_signals_if.rest     gsi,
  input  logic [NUM_REQ-1:0] get_bus,
  input  logic [NUM_REQ-1:0] lock,
  output logic [1:0][7:0]    select,
  output logic [NUM_REQ-1:0] granted
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  typedef enum logic {BUS_IDLE, BUS_OWNED} bus_state_t;

  bus_state_t        state_q [2];
  bus_state_t        state_d [2];
  logic [IW-1:0]     owner_q [2];
  logic [IW-1:0]     owner_d [2];
  logic [HW-1:0]     hold_q  [2];
  logic [HW-1:0]     hold_d  [2];
  logic [IW-1:0]     rr_q;
  logic [IW-1:0]     rr_d;

  logic [NUM_REQ-1:0] own_mask [2];
  logic [1:0]         wants_keep;
  logic [1:0]         keep;
  logic [NUM_REQ-1:0] kept_mask;
  logic [NUM_REQ-1:0] hit_mask;
  logic [NUM_REQ-1:0] base;
  logic [NUM_REQ-1:0] cand;
  logic               found_first;
  logic               found_second;
  logic [IW-1:0]      first_idx;
  logic [IW-1:0]      second_idx;
  logic               any_new;
  logic [IW-1:0]      last_idx;

  always_ff @(posedge gsi.clk) begin
    if (gsi.reset) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BUS_IDLE;
        owner_q[b] <= '0;
        hold_q[b]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        owner_q[b] <= owner_d[b];
        hold_q[b]  <= hold_d[b];
      end
      rr_q <= rr_d;
    end
  end

  // Owners still locking at the hold limit step aside only when someone else is waiting.
  always_comb begin
    int idx;
    idx       = 0;
    kept_mask = '0;
    hit_mask  = '0;
    for (int b = 0; b < 2; b++) begin
      own_mask[b] = '0;
      if (state_q[b] == BUS_OWNED) own_mask[b][owner_q[b]] = 1'b1;
      wants_keep[b] = |(own_mask[b] & get_bus & lock);
      keep[b]       = wants_keep[b] && (hold_q[b] < HOLD_MAX);
      if (keep[b]) kept_mask = kept_mask | own_mask[b];
      if (wants_keep[b] && !keep[b]) hit_mask = hit_mask | own_mask[b];
    end
    base = get_bus & ~kept_mask;
    cand = (|(base & ~hit_mask)) ? (base & ~hit_mask) : base;

    found_first  = 1'b0;
    found_second = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (cand[idx]) begin
        if (!found_first) begin
          found_first = 1'b1;
          first_idx   = IW'(idx);
        end else if (!found_second) begin
          found_second = 1'b1;
          second_idx   = IW'(idx);
        end
      end
    end

    for (int b = 0; b < 2; b++) begin
      owner_d[b] = owner_q[b];
      if (keep[b]) begin
        state_d[b] = BUS_OWNED;
        hold_d[b]  = hold_q[b] + HOLD_ONE;
      end else begin
        state_d[b] = BUS_IDLE;
        hold_d[b]  = '0;
      end
    end

    any_new  = 1'b0;
    last_idx = '0;
    if (found_first) begin
      if (!keep[0]) begin
        state_d[0] = BUS_OWNED;
        owner_d[0] = first_idx;
        hold_d[0]  = HOLD_ONE;
        any_new    = 1'b1;
        last_idx   = first_idx;
        if (!keep[1] && found_second) begin
          state_d[1] = BUS_OWNED;
          owner_d[1] = second_idx;
          hold_d[1]  = HOLD_ONE;
          last_idx   = second_idx;
        end
      end else if (!keep[1]) begin
        state_d[1] = BUS_OWNED;
        owner_d[1] = first_idx;
        hold_d[1]  = HOLD_ONE;
        any_new    = 1'b1;
        last_idx   = first_idx;
      end
    end

    rr_d = rr_q;
    if (any_new) rr_d = (last_idx == LAST_REQ) ? '0 : last_idx + IW'(1);

    // A flush drops every grant and lock but keeps the fairness pointer where it was.
    if (gsi.delete) begin
      for (int b = 0; b < 2; b++) begin
        state_d[b] = BUS_IDLE;
        hold_d[b]  = '0;
      end
      rr_d = rr_q;
    end
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < 2; b++) begin
      if (state_q[b] == BUS_OWNED) begin
        select[b]           = 8'(owner_q[b]);
        granted[owner_q[b]] = 1'b1;
      end else begin
        select[b] = IDLE_ADDR;
      end
    end
  end

  sel_distinct: assert property (@(posedge gsi.clk) disable iff (gsi.reset)
    (select[0] != select[1]) || (select[0] == IDLE_ADDR));

  grant_count: assert property (@(posedge gsi.clk) disable iff (gsi.reset)
    $countones(granted) <= 2);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant_match
    grant_matches_select: assert property (@(posedge gsi.clk) disable iff (gsi.reset)
      granted[i] == ((select[0] == 8'(i)) || (select[1] == 8'(i))));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a list-based reference model predicts each
// cycle's select/granted, and an independent monitor pops and compares them.
module tb_cdb_arbiter;
  localparam int NUM_REQ  = 8;
  localparam int MAX_HOLD = 4;

  global_signals_if gsi();
  logic [NUM_REQ-1:0] get_bus;
  logic [NUM_REQ-1:0] lock;
  logic [1:0][7:0]    select;
  logic [NUM_REQ-1:0] granted;

  cdb_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_HOLD  (MAX_HOLD),
    .IDLE_ADDR (8'hFF)
  ) dut (
    .gsi     (gsi),
    .get_bus (get_bus),
    .lock    (lock),
    .select  (select),
    .granted (granted)
  );

  initial begin
    gsi.clk = 1'b0;
    forever #5 gsi.clk = ~gsi.clk;
  end

  int          m_owner [2];
  int          m_hold  [2];
  int          m_rr;
  logic [23:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  // Owner -1 means the bus is free; candidates are listed in rotation order, then dealt to buses.
  task automatic model_step(input bit rst, input bit del, input logic [NUM_REQ-1:0] gb,
                            input logic [NUM_REQ-1:0] lk, output logic [23:0] expv);
    bit   keep [2];
    bit   blocked [NUM_REQ];
    bit   limit [NUM_REQ];
    bit   others;
    int   order [$];
    int   last;
    logic [7:0] sel [2];
    logic [NUM_REQ-1:0] gmask;
    last = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      blocked[i] = 1'b0;
      limit[i]   = 1'b0;
    end
    if (rst) begin
      m_owner[0] = -1; m_owner[1] = -1;
      m_hold[0] = 0;   m_hold[1] = 0;
      m_rr = 0;
    end else if (del) begin
      m_owner[0] = -1; m_owner[1] = -1;
      m_hold[0] = 0;   m_hold[1] = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        keep[b] = 1'b0;
        if (m_owner[b] >= 0 && gb[m_owner[b]] && lk[m_owner[b]]) begin
          if (m_hold[b] < MAX_HOLD) begin
            keep[b] = 1'b1;
            blocked[m_owner[b]] = 1'b1;
          end else begin
            limit[m_owner[b]] = 1'b1;
          end
        end
      end
      others = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        if (gb[i] && !blocked[i] && !limit[i]) others = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_rr + k) % NUM_REQ;
        if (gb[i] && !blocked[i] && !(limit[i] && others)) order.push_back(i);
      end
      for (int b = 0; b < 2; b++) begin
        if (keep[b]) begin
          m_hold[b]++;
        end else begin
          m_owner[b] = -1;
          m_hold[b]  = 0;
          if (order.size() > 0) begin
            m_owner[b] = order.pop_front();
            m_hold[b]  = 1;
            last       = m_owner[b];
          end
        end
      end
      if (last >= 0) m_rr = (last + 1) % NUM_REQ;
    end
    gmask = '0;
    for (int b = 0; b < 2; b++) begin
      if (m_owner[b] < 0) begin
        sel[b] = 8'hFF;
      end else begin
        sel[b] = 8'(m_owner[b]);
        gmask[m_owner[b]] = 1'b1;
      end
    end
    expv = {sel[0], sel[1], gmask};
  endtask

  task automatic applyStimulus(input bit rst, input bit del, input logic [NUM_REQ-1:0] gb,
                               input logic [NUM_REQ-1:0] lk);
    logic [23:0] expv;
    @(negedge gsi.clk);
    gsi.reset  = rst;
    gsi.delete = del;
    get_bus    = gb;
    lock       = lk;
    model_step(rst, del, gb, lk, expv);
    exp_q.push_back(expv);
  endtask

  task automatic checkOutput();
    logic [23:0] expv;
    logic [23:0] act;
    expv = exp_q.pop_front();
    act  = {select[0], select[1], granted};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL cdb_outputs @%0t: got sel0=%h sel1=%h granted=%b, expected sel0=%h sel1=%h granted=%b",
               $time, act[23:16], act[15:8], act[7:0], expv[23:16], expv[15:8], expv[7:0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge gsi.clk);
      #1;
      if (exp_q.size() > 0) checkOutput();
    end
  end

  initial begin
    logic [NUM_REQ-1:0] gb;
    logic [NUM_REQ-1:0] lk;
    gsi.reset  = 1'b1;
    gsi.delete = 1'b0;
    get_bus    = '0;
    lock       = '0;

    repeat (3) applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00);

    applyStimulus(1'b0, 1'b0, 8'h04, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (10) applyStimulus(1'b0, 1'b0, 8'hFF, 8'h00);

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (12) applyStimulus(1'b0, 1'b0, 8'h68, 8'h08);

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h28, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h28, 8'h08);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h28, 8'h08);

    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (10) applyStimulus(1'b0, 1'b0, 8'h80, 8'h80);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    gb = 8'(($urandom));
    for (int n = 0; n < 400; n++) begin
      gb = gb ^ 8'(($urandom & $urandom & $urandom));
      lk = 8'(($urandom | $urandom));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, gb, lk);
    end

    repeat (3) @(posedge gsi.clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
